// File: rtl/operand_serializer_pkg.sv
// Shared types and constants for the bit-serial operand transmitter.
// Build option: SERTX_PARITY_EN adds a trailing even-parity bit per lane.
package operand_serializer_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LANES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int lane_lo(
    input int width,
    input int lane
  );
    return width * lane;
  endfunction

endpackage

// File: rtl/serializer_lane.sv
// One serial lane: parallel-load shift register with MSB tap.
// Build option: SERTX_PARITY_EN latches the word's even parity at load.
module serializer_lane
  import operand_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  state_t           state,
  input  logic [WIDTH-1:0] din,
  output logic             tap
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef SERTX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^din;
    end
  end
`endif

  // Line is quiet in IDLE so the consumer shifts in zeros
  always_comb begin
    tap = 1'b0;
    unique case (state)
      SHIFT:   tap = sr_q[WIDTH-1];
`ifdef SERTX_PARITY_EN
      PARITY:  tap = par_q;
`endif
      default: tap = 1'b0;
    endcase
  end

endmodule

// File: rtl/operand_serializer.sv
// Multi-lane MSB-first serializer with valid/ready word intake.
// Build option: SERTX_PARITY_EN appends one even-parity bit per word.
module operand_serializer
  import operand_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   ser_en,
  output logic [LANES-1:0]       ser_out,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("operand_serializer: WIDTH must be >= 2");
  end

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          done_q;
  logic          done_d;
  logic          load;
  logic          shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          shift = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef SERTX_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef SERTX_PARITY_EN
      PARITY: begin
        if (ser_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    serializer_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .shift(shift),
      .state(state_q),
      .din  (in_data[lane_lo(WIDTH, i) +: WIDTH]),
      .tap  (ser_out[i])
    );
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_operand_serializer.sv
// Randomized bench for operand_serializer against a bit-stream model.
// Build option: SERTX_PARITY_EN expects one trailing parity bit per word.
module tb_operand_serializer;

  localparam int W = 32;
  localparam int L = 3;
`ifdef SERTX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [L*W-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           ser_en = 1'b0;
  logic           in_ready;
  logic [L-1:0]   ser_out;
  logic           busy;
  logic           done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  operand_serializer #(
    .WIDTH(W),
    .LANES(L)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ser_en  (ser_en),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Bit k of the serial stream: MSB first, then optional parity
  function automatic logic exp_bit(
    input logic [W-1:0] w,
    input int           k
  );
    if (k < W) return w[W-1-k];
    return ^w;
  endfunction

  function automatic logic [63:0] exp_load(input logic [W-1:0] w);
`ifdef SERTX_PARITY_EN
    return 64'({w, ^w});
`else
    return 64'(w);
`endif
  endfunction

  // Entered away from a clock edge with the DUT idle (or in its done cycle)
  task automatic send(
    input logic [W-1:0] w0,
    input logic [W-1:0] w1,
    input logic [W-1:0] w2,
    input int           stall_at,
    input int           stall_len,
    input bit           rnd_en,
    input bit           hold_valid,
    input int           abort_at
  );
    logic [W-1:0] wd [L];
    logic [63:0]  cap [L];
    logic [L-1:0] exp_o;
    int           k;
    int           stl;
    wd[0] = w0;
    wd[1] = w1;
    wd[2] = w2;
    for (int i = 0; i < L; i++) cap[i] = '0;
    in_data  = {w2, w1, w0};
    in_valid = 1'b1;
    #1;
    check("acc_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    if (!hold_valid) in_valid = 1'b0;
    k   = 0;
    stl = 0;
    for (int cyc = 0; cyc < 4 * NB + 64 && k < NB; cyc++) begin
      if (k == abort_at) begin
        ser_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_ser_out", 64'(ser_out), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(1));
        #1 reset = 1'b0;
        return;
      end
      if (hold_valid) in_data = {$urandom, $urandom, $urandom};
      if (k == stall_at && stl < stall_len) begin
        ser_en = 1'b0;
        stl++;
      end else if (rnd_en) begin
        ser_en = ($urandom_range(0, 3) != 0);
      end else begin
        ser_en = 1'b1;
      end
      @(negedge clk);
      for (int i = 0; i < L; i++) exp_o[i] = exp_bit(wd[i], k);
      check("ser_out", 64'(ser_out), 64'(exp_o));
      check("busy", 64'(busy), 64'(1));
      check("done_early", 64'(done), 64'(0));
      check("ready_busy", 64'(in_ready), 64'(0));
      if (ser_en) begin
        for (int i = 0; i < L; i++) cap[i] = {cap[i][62:0], ser_out[i]};
      end
      @(posedge clk);
      #1;
      if (ser_en) k++;
    end
    if (k < NB) begin
      check("timeout", 64'(k), 64'(NB));
      return;
    end
    @(negedge clk);
    check("done", 64'(done), 64'(1));
    check("busy_end", 64'(busy), 64'(0));
    check("ready_end", 64'(in_ready), 64'(1));
    check("ser_out_idle", 64'(ser_out), 64'(0));
    for (int i = 0; i < L; i++) check("loaded", cap[i], exp_load(wd[i]));
  endtask

  task automatic idle_cycle;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
    check("idle_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("init_ready", 64'(in_ready), 64'(1));
    check("init_busy", 64'(busy), 64'(0));
    check("init_done", 64'(done), 64'(0));
    check("init_ser_out", 64'(ser_out), 64'(0));

    send(32'h8000_0001, 32'h0, 32'h0, -1, 0, 0, 0, -1);
    idle_cycle();
    send(32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, -1, 0, 0, 0, -1);
    idle_cycle();
    send(32'hCAFE_F00D, 32'h0F0F_0F0F, 32'h8765_4321, 10, 5, 0, 0, -1);
    idle_cycle();
    send(32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, -1, 0, 0, 0, 17);
    @(negedge clk);
    check("post_rst_done", 64'(done), 64'(0));
    send(32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, -1, 0, 0, 0, -1);
    idle_cycle();

    send(32'h1, 32'h2, 32'h1, -1, 0, 0, 1, -1);
    send(32'h2, 32'h1, 32'h2, -1, 0, 0, 1, -1);
    send(32'h1, 32'h2, 32'h1, -1, 0, 0, 1, -1);
    in_valid = 1'b0;
    send(32'h2, 32'h1, 32'h2, -1, 0, 0, 0, -1);
    idle_cycle();

    send(32'h7, 32'h3, 32'h7, -1, 0, 0, 0, -1);
    send(32'h3, 32'h7, 32'h0, -1, 0, 0, 0, -1);
    idle_cycle();

    for (int n = 0; n < 20; n++) begin
      send($urandom, $urandom, $urandom, $urandom_range(0, NB - 1),
           $urandom_range(0, 3), 1, 0, -1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
